prbs_gen_chk: RTL

Parametrised PRBS engine with a W-bit-per-cycle Fibonacci LFSR generator and an independent self-synchronising checker. The checker has a lock state machine and a saturating bit-error counter. It sits in test and bring-up datapaths: the generator drives a link or memory under test, and the checker validates what comes back.

---
 rtl/prbs_gen_chk_if.sv | 23 ++
 rtl/prbs_gen_chk.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/prbs_gen_chk_if.sv
// rtl/prbs_gen_chk_if.sv - generator output and checker input word streams
interface prbs_gen_chk_if #(
    parameter int W = 4
);
    logic [W-1:0] gen_data;
    logic         gen_valid;
    logic         chk_valid;
    logic [W-1:0] chk_data;

    modport master (
        output gen_data,
        output gen_valid,
        input  chk_valid,
        input  chk_data
    );

    modport slave (
        input  gen_data,
        input  gen_valid,
        output chk_valid,
        output chk_data
    );
endinterface

// File: rtl/prbs_gen_chk.sv
// rtl/prbs_gen_chk.sv - W-bit/cycle Fibonacci PRBS generator with self-synchronising lock/error checker
// PRBS_ERR_INJECT_EN adds err_inj, which flips the earliest bit of a generated word.
module prbs_gen_chk #(
    parameter int           N          = 8,
    parameter logic [N:0]   TAP        = 9'b101110001,
    parameter logic [N-1:0] SEED       = 8'h4B,
    parameter int           W          = 4,
    parameter int           LOCK_CNT   = 4,
    parameter int           UNLOCK_CNT = 4,
    parameter int           CW         = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
`ifdef PRBS_ERR_INJECT_EN
    input  logic          err_inj,
`endif
    input  logic          err_clr,
    output logic          locked,
    output logic [CW-1:0] err_cnt,
    prbs_gen_chk_if.master bus
);
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(UNLOCK_CNT + 1);
    localparam int EW = $clog2(W + 1);
    localparam int SW = CW + 1;

    typedef enum logic {ST_SEARCH, ST_LOCKED} state_t;

    state_t        state, state_nxt;
    logic [N-1:0]  g, g_nxt, gs;
    logic [W-1:0]  g_word, inj_mask;
    logic [N-1:0]  h, h_nxt, hs;
    logic [W-1:0]  mism;
    logic          e_bit;
    logic          word_err;
    logic [EW-1:0] n_err;
    logic [SW-1:0] err_sum;
    logic [GW-1:0] good_cnt;
    logic [BW-1:0] bad_cnt;

    // Unroll W serial LFSR steps; the earliest output bit lands in the MSB.
    always_comb begin
        gs     = g;
        g_word = '0;
        for (int k = 0; k < W; k++) begin
            g_word[W-1-k] = gs[N-1];
            gs = {gs[N-2:0], ^(gs & TAP[N:1])};
        end
        g_nxt = gs;
    end

`ifdef PRBS_ERR_INJECT_EN
    always_comb begin
        inj_mask      = '0;
        inj_mask[W-1] = err_inj;
    end
`else
    assign inj_mask = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g             <= SEED;
            bus.gen_data  <= '0;
            bus.gen_valid <= 1'b0;
        end else begin
            bus.gen_valid <= en;
            if (en) begin
                g            <= g_nxt;
                bus.gen_data <= g_word ^ inj_mask;
            end
        end
    end

    // SEARCH feeds received bits into the history; LOCKED free-runs on predictions.
    always_comb begin
        hs    = h;
        mism  = '0;
        e_bit = 1'b0;
        for (int k = 0; k < W; k++) begin
            e_bit         = ^(hs & TAP[N:1]);
            mism[W-1-k]   = e_bit ^ bus.chk_data[W-1-k];
            hs = {hs[N-2:0], (state == ST_LOCKED) ? e_bit : bus.chk_data[W-1-k]};
        end
        h_nxt = hs;
    end

    assign word_err = (|mism) || ((state == ST_SEARCH) && (h == '0));
    assign n_err    = EW'($countones(mism));
    assign err_sum  = {1'b0, err_cnt} + SW'(n_err);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_SEARCH;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.chk_valid) begin
            case (state)
                ST_SEARCH: if (!word_err && good_cnt == GW'(LOCK_CNT - 1))  state_nxt = ST_LOCKED;
                ST_LOCKED: if (word_err && bad_cnt == BW'(UNLOCK_CNT - 1)) state_nxt = ST_SEARCH;
                default:   state_nxt = ST_SEARCH;
            endcase
        end
    end

    always_comb begin
        locked = (state == ST_LOCKED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h        <= '0;
            good_cnt <= '0;
            bad_cnt  <= '0;
        end else if (bus.chk_valid) begin
            h <= h_nxt;
            if (state == ST_SEARCH) begin
                good_cnt <= word_err ? '0 : good_cnt + GW'(1);
                if (state_nxt == ST_LOCKED) bad_cnt <= '0;
            end else begin
                bad_cnt <= word_err ? bad_cnt + BW'(1) : '0;
                if (state_nxt == ST_SEARCH) good_cnt <= '0;
            end
        end
    end

    // Clear takes priority over the errors of a coincident word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= '0;
        end else if (bus.chk_valid && state == ST_LOCKED) begin
            err_cnt <= err_sum[CW] ? '1 : err_sum[CW-1:0];
        end
    end
endmodule
